// File: rtl/scie_resp_queue.sv
// rtl/scie_resp_queue.sv - delays SCIE result-producing reads and queues io_rd for writeback
module scie_resp_queue #(
  parameter int         LATENCY     = 1,
  parameter int         DEPTH       = 4,
  parameter logic [6:0] RESP_OPCODE = 7'h5B
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_issue_valid,
  input  logic [31:0] io_issue_insn,
  output logic        io_issue_ready,
  input  logic [31:0] io_scie_rd,
  output logic        io_resp_valid,
  input  logic        io_resp_ready,
  output logic [31:0] io_resp_data,
  output logic [4:0]  io_resp_rd_idx
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int OW = $clog2(DEPTH + LATENCY + 2) + 1;

  logic               is_read;
  logic               fire;
  logic               push;
  logic               pop;
  logic [LATENCY-1:0] pipe_v;
  logic [4:0]         pipe_idx [LATENCY];
  logic               cap_v;
  logic [4:0]         cap_idx;
  logic [31:0]        cap_data;
  logic [36:0]        mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      fifo_count;
  logic [OW-1:0]      inflight_count;
  logic [OW-1:0]      occupancy;

  assign is_read = (io_issue_insn[6:0] == RESP_OPCODE) && (io_issue_insn[11:7] != 5'd0);

  // The capture register holds a reserved slot too, so it is counted as in flight.
  always_comb begin
    inflight_count = OW'(cap_v);
    for (int i = 0; i < LATENCY; i++) begin
      inflight_count = inflight_count + OW'(pipe_v[i]);
    end
  end

  assign occupancy      = OW'(fifo_count) + inflight_count;
  assign io_issue_ready = !is_read || (occupancy < OW'(DEPTH));
  assign fire           = io_issue_valid && io_issue_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pipe_v   <= '0;
      cap_v    <= 1'b0;
      cap_idx  <= '0;
      cap_data <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_idx[i] <= '0;
      end
    end else begin
      pipe_v[0]   <= fire && is_read;
      pipe_idx[0] <= io_issue_insn[11:7];
      for (int i = 1; i < LATENCY; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end
      cap_v   <= pipe_v[LATENCY-1];
      cap_idx <= pipe_idx[LATENCY-1];
      if (pipe_v[LATENCY-1]) begin
        cap_data <= io_scie_rd;
      end
    end
  end

  assign push = cap_v;
  assign pop  = io_resp_valid && io_resp_ready;

  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= {cap_data, cap_idx};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign io_resp_valid  = (fifo_count != '0);
  assign io_resp_data   = io_resp_valid ? mem[rd_ptr][36:5] : 32'd0;
  assign io_resp_rd_idx = io_resp_valid ? mem[rd_ptr][4:0]  : 5'd0;

endmodule

// File: doc/scie_resp_queue.md
Name: scie_resp_queue

Overview:
- Downstream stage of SCIEPipelined.
- Snoops every SCIE instruction the core issues, identifies result-producing reads (custom-2 opcode), and delays each one by the SCIE pipeline latency.
- Captures io_rd together with the destination register index into a small FIFO and presents it to core writeback over a valid/ready handshake.
- Back-pressures issue with a credit check so a captured result is never dropped.

Parameters:
- LATENCY, 1, cycles from the issue clock edge to the edge at which SCIEPipelined io_rd is sampled; ≥1.
- DEPTH, 4, response FIFO entries; power of two, ≥2.
- RESP_OPCODE, 7'h5B, insn[6:0] value that produces a result (custom-2).

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- io_issue_valid  in  1  core presents an SCIE instruction this cycle; same as the SCIEPipelined io_valid source.
- io_issue_insn  in  32  instruction word; same as the SCIEPipelined io_insn source.
- io_issue_ready  out  1  core may fire the instruction (fire = valid & ready); core gates SCIEPipelined io_valid with fire.
- io_scie_rd  in  32  SCIEPipelined io_rd.
- io_resp_valid  out  1  head FIFO entry available.
- io_resp_ready  in  1  writeback accepts the head entry.
- io_resp_data  out  32  result value.
- io_resp_rd_idx  out  5  destination register (insn[11:7] of the originating read).

Behaviour:
- is_read = insn[6:0]==RESP_OPCODE && insn[11:7]!=0.
  - Reads to x0 and non-read opcodes (e.g. 0x0B coefficient load, 0x2B sample push) produce no entry and consume no credit.
- Credit:
  - occupancy = fifo_count + inflight_count, both from registered state only; no same-cycle pop bypass.
  - io_issue_ready = !is_read || occupancy < DEPTH.
  - Non-read instructions are always ready.
- Inflight pipe: LATENCY-stage shift register of {v, idx[4:0]}.
  - Stage 0 loads {fire & is_read, insn[11:7]} at the fire edge.
  - The pipe advances every cycle; it never stalls.
  - inflight_count = number of set v bits.
- Capture:
  - When the last stage has v=1, the block pushes {io_scie_rd, idx} into the FIFO at the next rising edge.
  - For LATENCY=1, a read fired at edge k pushes io_scie_rd as sampled at edge k+1.
- FIFO:
  - Circular buffer with wr_ptr, rd_ptr (log2 DEPTH bits, wrap modulo DEPTH) and fifo_count (log2 DEPTH+1 bits).
  - Pop = io_resp_valid & io_resp_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Push when full cannot occur by construction; the bench asserts fifo_count<=DEPTH.
  - Pop when empty is ignored.
- Outputs:
  - io_resp_valid = fifo_count!=0.
  - io_resp_data and io_resp_rd_idx show the head entry when valid and are forced to 0 when empty.
  - The handshake is in-order; data stays stable while valid & !ready.
- Reset (async, any time, including mid-flight):
  - pointers, fifo_count and all pipe v bits go to 0;
  - io_resp_valid=0, io_resp_data=0, io_resp_rd_idx=0;
  - io_issue_ready=1;
  - inflight results are dropped.
  - Storage array contents are not reset.
- Latency: read fire at edge k → io_resp_valid high after edge k+LATENCY+1 if the FIFO was empty. There is no combinational path from io_scie_rd to outputs.

Test Plan:
- FIR flow, LATENCY=1, resp_ready=1:
  - load coefficients -38,-98,-80,-83,-66 (insn 0x0B, rs2 = index 0..4), push sample -67 (insn 0x2B);
  - read with insn 0x5B | (5<<7) → one response, data 2546, rd_idx 5;
  - further samples -93, -39 give data 10100, then 15956.
- Back-pressure, resp_ready=0:
  - fire 4 reads to x1..x4 → io_issue_ready drops to 0 for a 5th read in the cycle after the 4th fire;
  - a 0x2B push still fires;
  - raise resp_ready → entries drain in order x1..x4, and ready reasserts the cycle after the first pop edge.
- Read to x0 (insn 0x5B): no response appears; occupancy unchanged.
- Simultaneous push and pop with a steady read stream, resp_ready=1: fifo_count stays at 1; pointers wrap past DEPTH-1 with no loss or duplication.
- Reset asserted one cycle after a read fire: io_resp_valid stays 0 afterward, io_issue_ready=1 immediately, and no stale entry appears after release.
- LATENCY=3 build: response appears exactly 4 edges after the fire edge, with data equal to io_scie_rd at edge k+3.
